// File: rtl/bin_to_bcd_sequencer_if.sv
// Handshake and datapath bundle between the binary-to-BCD sequencer, its producer/consumer
// and the external BCD doubling stage.
interface bin_to_bcd_sequencer_if #(
    parameter int numberOfDigits = 3,
    parameter int binWidth       = 10
);
    logic [binWidth-1:0]         binIn;
    logic                        binValid;
    logic                        binReady;
    logic [4*numberOfDigits-1:0] bcdOut;
    logic                        bcdOverflow;
    logic                        bcdValid;
    logic                        bcdReady;
    logic [4*numberOfDigits-1:0] dpDigitIn;
    logic                        dpDigitCIn;
    logic [4*numberOfDigits-1:0] dpDigitOut;
    logic                        dpDigitCOut;

    modport slave (
        input  binIn, binValid, bcdReady, dpDigitOut, dpDigitCOut,
        output binReady, bcdOut, bcdOverflow, bcdValid, dpDigitIn, dpDigitCIn
    );

    modport master (
        output binIn, binValid, bcdReady, dpDigitOut, dpDigitCOut,
        input  binReady, bcdOut, bcdOverflow, bcdValid, dpDigitIn, dpDigitCIn
    );
endinterface

// File: rtl/bin_to_bcd_sequencer.sv
// Double-dabble style controller: feeds one binary bit per step (MSB first) into an
// external BCD doubling stage and accumulates the packed BCD result.
module bin_to_bcd_sequencer #(
    parameter int numberOfDigits = 3,
    parameter int binWidth       = 10,
    parameter int dpLatency      = 1
) (
    input logic                    clk,
    input logic                    rst,
    bin_to_bcd_sequencer_if.slave  bus
);
    localparam int StepW = (dpLatency > 0) ? $clog2(dpLatency + 1) : 1;
    localparam int BitW  = (binWidth > 1) ? $clog2(binWidth) : 1;

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t                      stateReg;
    logic                        binReadyReg;
    logic                        bcdValidReg;
    logic [4*numberOfDigits-1:0] bcdOutReg;
    logic                        bcdOverflowReg;
    logic [4*numberOfDigits-1:0] accReg;
    logic                        bitReg;
    logic                        ovfReg;
    logic [binWidth-1:0]         shiftReg;
    logic [binWidth-1:0]         shiftNext;
    logic [BitW-1:0]             bitCnt;
    logic [StepW-1:0]            stepCnt;

    assign shiftNext = shiftReg << 1;

    // accReg/bitReg are the datapath operands; they only change on a capture edge,
    // so the stage sees constant inputs for the full dpLatency+1 cycles of a step.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg       <= IDLE;
            binReadyReg    <= 1'b1;
            bcdValidReg    <= 1'b0;
            bcdOutReg      <= '0;
            bcdOverflowReg <= 1'b0;
            accReg         <= '0;
            bitReg         <= 1'b0;
            ovfReg         <= 1'b0;
            shiftReg       <= '0;
            bitCnt         <= '0;
            stepCnt        <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (bus.binValid) begin
                        shiftReg    <= bus.binIn;
                        accReg      <= '0;
                        bitReg      <= bus.binIn[binWidth-1];
                        ovfReg      <= 1'b0;
                        bitCnt      <= BitW'(binWidth - 1);
                        stepCnt     <= '0;
                        binReadyReg <= 1'b0;
                        stateReg    <= STEP;
                    end
                end
                STEP: begin
                    if (stepCnt == StepW'(dpLatency)) begin
                        accReg   <= bus.dpDigitOut;
                        ovfReg   <= ovfReg | bus.dpDigitCOut;
                        shiftReg <= shiftNext;
                        bitReg   <= shiftNext[binWidth-1];
                        stepCnt  <= '0;
                        if (bitCnt == '0) begin
                            bcdOutReg      <= bus.dpDigitOut;
                            bcdOverflowReg <= ovfReg | bus.dpDigitCOut;
                            bcdValidReg    <= 1'b1;
                            stateReg       <= DONE;
                        end else begin
                            bitCnt <= bitCnt - 1'b1;
                        end
                    end else begin
                        stepCnt <= stepCnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.bcdReady) begin
                        bcdValidReg <= 1'b0;
                        binReadyReg <= 1'b1;
                        stateReg    <= IDLE;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign bus.binReady    = binReadyReg;
    assign bus.bcdValid    = bcdValidReg;
    assign bus.bcdOut      = bcdOutReg;
    assign bus.bcdOverflow = bcdOverflowReg;
    assign bus.dpDigitIn   = accReg;
    assign bus.dpDigitCIn  = bitReg;
endmodule

// File: tb/tb_bin_to_bcd_sequencer.sv
// Directed bench: four sequencer configurations, each paired with a behavioural BCD
// doubling stage of matching latency; one shared stimulus port selected by sel.
module tb_bin_to_bcd_sequencer;
    logic       clk;
    logic       rst;
    logic [9:0] binIn;
    logic       binValid;
    logic       bcdReady;
    int         sel;
    int         total;
    int         bad;

    logic [15:0] bcdOutM;
    logic        ovfM, validM, readyM;
    logic [16:0] dpM;

    bin_to_bcd_sequencer_if #(.numberOfDigits(3), .binWidth(10)) ifA();
    bin_to_bcd_sequencer_if #(.numberOfDigits(4), .binWidth(10)) ifB();
    bin_to_bcd_sequencer_if #(.numberOfDigits(3), .binWidth(10)) ifC();
    bin_to_bcd_sequencer_if #(.numberOfDigits(3), .binWidth(10)) ifD();

    bin_to_bcd_sequencer #(.numberOfDigits(3), .binWidth(10), .dpLatency(1))
        dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
    bin_to_bcd_sequencer #(.numberOfDigits(4), .binWidth(10), .dpLatency(1))
        dutB (.clk(clk), .rst(rst), .bus(ifB.slave));
    bin_to_bcd_sequencer #(.numberOfDigits(3), .binWidth(10), .dpLatency(0))
        dutC (.clk(clk), .rst(rst), .bus(ifC.slave));
    bin_to_bcd_sequencer #(.numberOfDigits(3), .binWidth(10), .dpLatency(3))
        dutD (.clk(clk), .rst(rst), .bus(ifD.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural number_2_10: ripple of per-digit 2*d+c with decimal carry.
    function automatic logic [16:0] bcdDouble(input logic [15:0] d, input int nd, input logic cin);
        logic [16:0] r;
        logic        c;
        logic [4:0]  t;
        r = '0;
        c = cin;
        for (int k = 0; k < nd; k++) begin
            t = {d[4*k +: 4], 1'b0} + 5'(c);
            if (t >= 5'd10) begin
                t = t - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*k +: 4] = t[3:0];
        end
        r[16] = c;
        return r;
    endfunction

    logic [16:0] rA, rB, rC, rD;
    logic [12:0] p1, p2, p3;
    assign rA = bcdDouble(16'(ifA.dpDigitIn), 3, ifA.dpDigitCIn);
    assign rB = bcdDouble(ifB.dpDigitIn, 4, ifB.dpDigitCIn);
    assign rC = bcdDouble(16'(ifC.dpDigitIn), 3, ifC.dpDigitCIn);
    assign rD = bcdDouble(16'(ifD.dpDigitIn), 3, ifD.dpDigitCIn);

    always @(posedge clk) begin
        ifA.dpDigitOut  <= rA[11:0];
        ifA.dpDigitCOut <= rA[16];
        ifB.dpDigitOut  <= rB[15:0];
        ifB.dpDigitCOut <= rB[16];
        p1 <= {rD[16], rD[11:0]};
        p2 <= p1;
        p3 <= p2;
    end
    assign ifC.dpDigitOut  = rC[11:0];
    assign ifC.dpDigitCOut = rC[16];
    assign ifD.dpDigitOut  = p3[11:0];
    assign ifD.dpDigitCOut = p3[12];

    assign ifA.binIn = binIn;  assign ifA.bcdReady = bcdReady;  assign ifA.binValid = binValid && (sel == 0);
    assign ifB.binIn = binIn;  assign ifB.bcdReady = bcdReady;  assign ifB.binValid = binValid && (sel == 1);
    assign ifC.binIn = binIn;  assign ifC.bcdReady = bcdReady;  assign ifC.binValid = binValid && (sel == 2);
    assign ifD.binIn = binIn;  assign ifD.bcdReady = bcdReady;  assign ifD.binValid = binValid && (sel == 3);

    always_comb begin
        bcdOutM = 16'(ifA.bcdOut); ovfM = ifA.bcdOverflow; validM = ifA.bcdValid;
        readyM = ifA.binReady; dpM = {ifA.dpDigitCIn, 16'(ifA.dpDigitIn)};
        case (sel)
            1: begin bcdOutM = ifB.bcdOut; ovfM = ifB.bcdOverflow; validM = ifB.bcdValid;
                     readyM = ifB.binReady; dpM = {ifB.dpDigitCIn, ifB.dpDigitIn}; end
            2: begin bcdOutM = 16'(ifC.bcdOut); ovfM = ifC.bcdOverflow; validM = ifC.bcdValid;
                     readyM = ifC.binReady; dpM = {ifC.dpDigitCIn, 16'(ifC.dpDigitIn)}; end
            3: begin bcdOutM = 16'(ifD.bcdOut); ovfM = ifD.bcdOverflow; validM = ifD.bcdValid;
                     readyM = ifD.binReady; dpM = {ifD.dpDigitCIn, 16'(ifD.dpDigitIn)}; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetA(input string tag);
        check({tag, "_binReady"}, 32'(ifA.binReady), 32'd1);
        check({tag, "_bcdValid"}, 32'(ifA.bcdValid), 32'd0);
        check({tag, "_bcdOut"}, 32'(ifA.bcdOut), 32'd0);
        check({tag, "_bcdOverflow"}, 32'(ifA.bcdOverflow), 32'd0);
        check({tag, "_dpDigitIn"}, 32'(ifA.dpDigitIn), 32'd0);
        check({tag, "_dpDigitCIn"}, 32'(ifA.dpDigitCIn), 32'd0);
    endtask

    // Presents v for one edge (the accept edge) and returns #1 after it.
    task automatic accept(input string tag, input logic [9:0] v);
        int w;
        w = 0;
        while (!readyM && w < 100) begin
            @(posedge clk); #1; w++;
        end
        check({tag, "_readyBeforeAccept"}, 32'(readyM), 32'd1);
        binIn = v;
        binValid = 1'b1;
        @(posedge clk); #1;
        binValid = 1'b0;
        check({tag, "_busyAfterAccept"}, 32'(readyM), 32'd0);
    endtask

    task automatic convert(input string tag, input int s, input logic [9:0] v,
                           input logic [15:0] expOut, input logic expOvf,
                           input int expLat, input int stepLen, input int holdCycles);
        int n;
        logic got, readyBad, stabBad;
        logic [16:0] prev;
        logic [15:0] held;
        sel = s;
        bcdReady = (holdCycles == 0);
        accept(tag, v);
        n = 0; got = 1'b0; readyBad = 1'b0; stabBad = 1'b0;
        prev = dpM;
        while (!got && n < 300) begin
            @(posedge clk); #1; n++;
            if (validM) begin
                got = 1'b1;
            end else begin
                if (readyM) readyBad = 1'b1;
                if ((n % stepLen) != 0 && dpM !== prev) stabBad = 1'b1;
                prev = dpM;
            end
        end
        check({tag, "_validSeen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(expLat));
        check({tag, "_readyLowWhileBusy"}, 32'(readyBad), 32'd0);
        check({tag, "_dpStableInStep"}, 32'(stabBad), 32'd0);
        check({tag, "_bcdOut"}, 32'(bcdOutM), 32'(expOut));
        check({tag, "_bcdOverflow"}, 32'(ovfM), 32'(expOvf));
        held = bcdOutM;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            check({tag, "_holdValid"}, 32'(validM), 32'd1);
            check({tag, "_holdOut"}, 32'(bcdOutM), 32'(held));
        end
        bcdReady = 1'b1;
        @(posedge clk); #1;
        check({tag, "_validDropped"}, 32'(validM), 32'd0);
        check({tag, "_readyBack"}, 32'(readyM), 32'd1);
        check({tag, "_outKept"}, 32'(bcdOutM), 32'(expOut));
        $display("txn %s: bin=%0d bcd=%0h ovf=%0b latency=%0d", tag, v, bcdOutM, ovfM, n);
    endtask

    initial begin
        total = 0; bad = 0; sel = 0;
        rst = 1'b1; binIn = '0; binValid = 1'b0; bcdReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetA("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        convert("t1_255", 0, 10'd255, 16'h0255, 1'b0, 20, 2, 0);
        convert("t2_999", 0, 10'd999, 16'h0999, 1'b0, 20, 2, 0);
        convert("t2_0", 0, 10'd0, 16'h0000, 1'b0, 20, 2, 0);
        convert("t3_1023_nd3", 0, 10'd1023, 16'h0023, 1'b1, 20, 2, 0);
        convert("t3_1023_nd4", 1, 10'd1023, 16'h1023, 1'b0, 20, 2, 0);
        convert("t4_512_bp", 0, 10'd512, 16'h0512, 1'b0, 20, 2, 15);

        // Reset during the 7th STEP cycle abandons the conversion of 700.
        sel = 0;
        accept("t5_700", 10'd700);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checkResetA("t5_midReset");
        rst = 1'b0;
        $display("txn t5_700: reset mid-conversion");
        convert("t5_42", 0, 10'd42, 16'h0042, 1'b0, 20, 2, 0);

        convert("t6_681_lat0", 2, 10'd681, 16'h0681, 1'b0, 10, 1, 0);
        convert("t6_681_lat3", 3, 10'd681, 16'h0681, 1'b0, 40, 4, 0);
        convert("t6_1000_lat0", 2, 10'd1000, 16'h0000, 1'b1, 10, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_sequencer.md
Name: bin_to_bcd_sequencer

Overview:
Controller that converts a binary word to packed BCD by sequencing the team's BCD doubling stage (number_2_10). The stage computes digitOut = 2*digitIn + digitCIn in BCD, with carry-out on decimal overflow. The controller feeds it one binary bit per step, MSB first, and holds the running BCD accumulator. It sits between a valid/ready binary producer and a valid/ready BCD consumer, for example a display driver.

Parameters:
numberOfDigits, 3, number of BCD digits in the accumulator and datapath (>=1)
binWidth, 10, width of the binary input (>=1)
dpLatency, 1, clock cycles from datapath input to valid datapath output (0 = combinational stage)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
binIn  in  binWidth  binary value to convert
binValid  in  1  binIn valid
binReady  out  1  sequencer can accept binIn
bcdOut  out  4*numberOfDigits  result; digit 0 in bits [3:0]
bcdOverflow  out  1  value >= 10**numberOfDigits; bcdOut holds value mod 10**numberOfDigits
bcdValid  out  1  bcdOut/bcdOverflow valid
bcdReady  in  1  consumer accepts result
dpDigitIn  out  4*numberOfDigits  to datapath digitIn (current accumulator)
dpDigitCIn  out  1  to datapath digitCIn (current binary bit)
dpDigitOut  in  4*numberOfDigits  from datapath digitOut
dpDigitCOut  in  1  from datapath digitCOut

Behaviour:
- Reset, synchronous active-high, checked every edge, overrides everything including mid-conversion:
  - state=IDLE; binReady=1; bcdValid=0; bcdOut=0; bcdOverflow=0; dpDigitIn=0; dpDigitCIn=0.
  - Any in-flight conversion is abandoned; no bcdValid is ever produced for it.
- FSM states: IDLE, STEP, DONE.
- IDLE:
  - binReady=1.
  - On an edge with binValid=1: load shift register with binIn, clear accumulator, clear sticky overflow, bitCnt=binWidth-1, stepCnt=0, go to STEP.
- STEP: binReady=0. Each step processes one bit and lasts dpLatency+1 cycles.
  - dpDigitIn=accumulator and dpDigitCIn=shift[binWidth-1] are registered and held constant for the whole step.
  - stepCnt increments each cycle.
  - On the edge where stepCnt==dpLatency: accumulator<=dpDigitOut; overflow<=overflow|dpDigitCOut; shift register shifts left by 1; stepCnt<=0.
  - If bitCnt==0 on that edge, go to DONE; otherwise bitCnt decrements.
  - With dpLatency=0, the capture happens on every edge (one cycle per bit).
- Arithmetic: acc_next = (2*acc + bit) mod 10**numberOfDigits, produced by the datapath. The controller does no BCD correction. Overflow is sticky across all steps.
- DONE:
  - bcdValid=1; bcdOut=accumulator; bcdOverflow=overflow; binReady=0.
  - bcdOut and bcdOverflow stay stable while bcdValid=1 and bcdReady=0 (backpressure, unbounded).
  - On an edge with bcdReady=1, go to IDLE and set bcdValid=0. bcdOut and bcdOverflow keep their last value until the next DONE.
- Latency: with accept edge E0, bcdValid is first high in the cycle after edge E0 + binWidth*(dpLatency+1). Defaults give 20 cycles.
- Throughput: one conversion in flight. binReady returns in the cycle after the bcdReady handshake, so no same-cycle accept of a new word on the result handshake.
- binValid while busy is ignored and binIn is not sampled. The producer must hold binIn until binReady=1.
- binWidth=1: a single step. Values are always < 10**numberOfDigits when 2**binWidth <= 10**numberOfDigits, so bcdOverflow=0 for all inputs in that case.

Test Plan:
1. Defaults, binIn=255, bcdReady=1 → bcdOut=0x255, bcdOverflow=0, bcdValid high exactly 20 cycles after the accept edge, for one cycle.
2. binIn=999 then binIn=0, back-to-back → 0x999 ovf=0, then 0x000 ovf=0. binReady is low throughout each conversion.
3. binIn=1023 (numberOfDigits=3) → bcdOut=0x023, bcdOverflow=1. Repeat with numberOfDigits=4 → 0x1023, overflow=0.
4. Backpressure: binIn=512 with bcdReady held 0 for 15 cycles → bcdValid=1 and bcdOut=0x512 held stable. Drop bcdReady=1 → next cycle bcdValid=0 and binReady=1.
5. Reset mid-conversion: accept 700, assert rst at the 7th cycle of STEP → next cycle all outputs at reset values. Then accept 42 → 0x042, with no stale bcdValid in between.
6. dpLatency=0 and dpLatency=3, with a matching datapath model: binIn=681 → 0x681 at 10 and 40 cycles after the accept edge respectively. Check dpDigitIn/dpDigitCIn are stable across each step.
